bus_slave_port: RTL and testbench

//  Responder end of the serial system bus: one instance sits behind each slave port of the bus interconnect.

---
 rtl/bus_pkg.sv | 6 +
 rtl/slave_bram.sv | 23 ++
 rtl/bus_slave_port.sv | 95 +++++++++
 tb/tb_bus_slave_port.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state encoding, transfer mode constants and default widths for the serial bus slave
package bus_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_WDATA = 3'd2, S_RMEM = 3'd3, S_RWAIT = 3'd4, S_RDATA = 3'd5;
  localparam logic MODE_READ = 1'b0, MODE_WRITE = 1'b1;
  localparam int DEF_ADDR_WIDTH = 12, DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/slave_bram.sv
// slave_bram: single-port synchronous RAM, DEPTH x WIDTH, one-cycle registered read, write enable
//   clk  - clock
//   we   - write din to mem[addr] on this edge
//   addr - word address for both read and write
//   din  - write data
//   dout - mem[addr] as it was before this edge
module slave_bram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 8,
  parameter int AW = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/bus_slave_port.sv
// bus_slave_port: serial bus responder; shifts in address/write data LSB first, serves local RAM, shifts read data back
//   clk, rst - clock, synchronous active-high reset
//   wdata    - serial address then write data, qualified by mvalid
//   mode     - 0 read / 1 write, taken with the first address bit
//   mvalid   - wdata bit valid
//   rdata    - serial read data, qualified by svalid
//   svalid   - rdata bit valid
//   ready    - high only while idle
// Optional: define BUS_SLAVE_RDELAY_EN to insert READ_DELAY wait cycles before read data.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH = 4096,
  parameter int READ_DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rdata,
  input  logic wdata,
  input  logic mode,
  input  logic mvalid,
  output logic svalid,
  output logic ready
);
  localparam int CW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
  localparam int MW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
`ifdef BUS_SLAVE_RDELAY_EN
  localparam int WAIT_CYC = READ_DELAY;
`else
  localparam int WAIT_CYC = READ_DELAY * 0;
`endif
  logic [2:0] state, state_n;
  logic [CW-1:0] bitcnt;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] rx_n, rx, tx, q;
  logic mode_q, a_last, d_last, in_rng, cnt_en, we;
  logic [MW-1:0] ram_addr;
  assign addr_n = {wdata, addr[ADDR_WIDTH-1:1]};
  assign rx_n = {wdata, rx[DATA_WIDTH-1:1]};
  assign a_last = bitcnt == CW'(ADDR_WIDTH - 1);
  assign d_last = bitcnt == CW'(DATA_WIDTH - 1);
  assign in_rng = {1'b0, addr} < DEPTH_LIM;
  assign cnt_en = (state == S_ADDR || state == S_WDATA) && mvalid || state == S_RDATA;
  // The RAM sees the address being completed during ADDR, so the word is ready in RMEM
  assign ram_addr = MW'(state == S_ADDR ? addr_n : addr);
  assign we = state == S_WDATA && mvalid && d_last && in_rng;
  slave_bram #(.DEPTH(MEM_DEPTH), .WIDTH(DATA_WIDTH), .AW(MW)) u_bram (
    .clk(clk), .we(we), .addr(ram_addr), .din(rx_n), .dout(q)
  );
`ifdef BUS_SLAVE_RDELAY_EN
  localparam int DLW = $clog2(WAIT_CYC + 2);
  logic [DLW-1:0] dly;
  always_ff @(posedge clk) dly <= rst || state != S_RWAIT ? '0 : dly + 1'b1;
`endif
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (mvalid) state_n = S_ADDR;
      S_ADDR:  if (mvalid && a_last) state_n = mode_q == MODE_WRITE ? S_WDATA : S_RMEM;
      S_WDATA: if (mvalid && d_last) state_n = S_IDLE;
      S_RMEM:  state_n = WAIT_CYC > 0 ? S_RWAIT : S_RDATA;
`ifdef BUS_SLAVE_RDELAY_EN
      S_RWAIT: if (dly == DLW'(WAIT_CYC - 1)) state_n = S_RDATA;
`endif
      S_RDATA: if (d_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    ready = state == S_IDLE;
    svalid = state == S_RDATA;
    rdata = svalid & tx[0];
  end
  // Counter restarts on every state change; the IDLE exit already consumed address bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt <= '0;
      addr <= '0;
      rx <= '0;
      tx <= '0;
      mode_q <= MODE_READ;
    end else begin
      bitcnt <= state_n != state ? CW'(state == S_IDLE) : cnt_en ? bitcnt + 1'b1 : bitcnt;
      if ((state == S_IDLE || state == S_ADDR) && mvalid) addr <= addr_n;
      if (state == S_IDLE && mvalid) mode_q <= mode;
      if (state == S_WDATA && mvalid) rx <= rx_n;
      if (state == S_RMEM) tx <= in_rng ? q : '0;
      else if (state == S_RDATA) tx <= tx >> 1;
    end
  end
endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port: directed and random transfers against a reference memory with a read-bit scoreboard
module tb_bus_slave_port;
  localparam int AW = 12, DW = 8, DEPTH = 1024, RD = 3;
`ifdef BUS_SLAVE_RDELAY_EN
  localparam int LAT = 2 + RD;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst = 1, wdata = 0, mode = 0, mvalid = 0;
  logic rdata, svalid, ready;
  int checks = 0, failures = 0, ready_hi = 0;
  logic exp_q[$];
  logic [DW-1:0] model [int];
  bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .wdata(wdata), .mode(mode),
    .mvalid(mvalid), .svalid(svalid), .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (svalid) begin
    if (exp_q.size() == 0) check("unexpected_svalid", 32'd1, 32'd0);
    else check("rdata_bit", {31'd0, rdata}, {31'd0, exp_q.pop_front()});
  end
  function automatic logic [DW-1:0] exp_of(input int a);
    return (a < DEPTH && model.exists(a)) ? model[a] : '0;
  endfunction
  task automatic step(input logic v, input logic b, input logic md);
    mvalid = v;
    wdata = b;
    mode = md;
    @(negedge clk);
    if (ready) ready_hi++;
    @(posedge clk);
    #1;
  endtask
  task automatic send_addr(input logic [AW-1:0] a, input logic md, input int spos, input int slen);
    for (int i = 0; i < AW; i++) begin
      if (i == spos) for (int s = 0; s < slen; s++) step(1'b0, 1'($urandom), 1'($urandom));
      step(1'b1, a[i], i == 0 ? md : 1'($urandom));
    end
  endtask
  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int sa, input int la,
                       input int sd, input int ld, input int abort);
    send_addr(a, 1'b1, sa, la);
    for (int i = 0; i < DW; i++) begin
      if (i == sd) for (int s = 0; s < ld; s++) step(1'b0, 1'($urandom), 1'($urandom));
      if (i == abort) begin
        rst = 1;
        step(1'b1, d[i], 1'b0);
        rst = 0;
        mvalid = 0;
        return;
      end
      step(1'b1, d[i], 1'($urandom));
    end
    mvalid = 0;
    if (int'(a) < DEPTH) model[int'(a)] = d;
  endtask
  task automatic read(input logic [AW-1:0] a);
    logic [DW-1:0] e;
    int n;
    e = exp_of(int'(a));
    for (int i = 0; i < DW; i++) exp_q.push_back(e[i]);
    send_addr(a, 1'b0, -1, 0);
    mvalid = 1'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!svalid && ready) ready_hi++;
    end while (!svalid && n < 20);
    check("read_latency", n, LAT);
    n = 0;
    while (svalid && n < DW + 4) begin
      if (ready) ready_hi++;
      @(negedge clk);
      n++;
    end
    mvalid = 0;
    check("rdata_len", n, DW);
    check("ready_after_read", {31'd0, ready}, 32'd1);
    check("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_rdata", {31'd0, rdata}, 32'd0);
    check("reset_svalid", {31'd0, svalid}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 0;
    write(12'h012, 8'hA5, -1, 0, -1, 0, -1);
    read(12'h012);
    write(12'h345, 8'h96, 4, 3, 5, 2, -1);
    @(negedge clk);
    check("ready_after_stalled_write", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    read(12'h345);
    write(12'h000, 8'h77, -1, 0, -1, 0, -1);
    write(12'h800, 8'h3C, -1, 0, -1, 0, -1);
    read(12'h800);
    read(12'h000);
    write(12'h3FF, 8'h81, -1, 0, -1, 0, -1);
    read(12'h3FF);
    write(12'hFFF, 8'hFF, -1, 0, -1, 0, -1);
    read(12'hFFF);
    read(12'h000);
    write(12'h0AB, 8'h11, -1, 0, -1, 0, -1);
    write(12'h0AB, 8'hEE, -1, 0, -1, 0, 3);
    @(negedge clk);
    check("abort_svalid", {31'd0, svalid}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    read(12'h0AB);
    write(12'h1F0, 8'h5A, -1, 0, -1, 0, -1);
    ready_hi = 0;
    write(12'h1F0, 8'hC3, -1, 0, -1, 0, -1);
    read(12'h1F0);
    check("b2b_ready_high_cycles", ready_hi, 2);
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(0, 1500));
      d = DW'($urandom);
      write(a, d, k, 1, k, 1, -1);
      read(a);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
